// File: rtl/usb_crc_pkg.sv
// Shared constants and types for the USB serial CRC checker.
//   CRC5_*  : token CRC generator polynomial and good-packet residue
//   CRC16_* : data-packet CRC generator polynomial and good-packet residue
//   crc_state_t : checker framing FSM states
package usb_crc_pkg;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} crc_state_t;

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC LFSR register with load and single-bit step.
//   clk, rst   : clock, asynchronous active-high reset (register -> INIT)
//   load       : restart from INIT this cycle (a same-cycle step applies to INIT)
//   step       : advance the LFSR by bit_in
//   bit_in     : serial data bit, LSB-first as on the wire
//   crc        : registered LFSR contents
//   crc_next_c : value the register takes at the next edge
module usb_crc_lfsr #(
  parameter int unsigned           CRC_WIDTH = 5,
  parameter logic [CRC_WIDTH-1:0]  POLY      = CRC_WIDTH'(5),
  parameter logic [CRC_WIDTH-1:0]  INIT      = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc,
  output logic [CRC_WIDTH-1:0] crc_next_c
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] base;
  logic                 fb;

  // Next value: optional reload, then optional Galois step on the chosen base.
  always_comb begin
    base       = load ? INIT : crc_q;
    fb         = base[CRC_WIDTH-1] ^ bit_in;
    crc_next_c = base;
    if (step) begin
      crc_next_c = {base[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= INIT;
    else     crc_q <= crc_next_c;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_crc_checker.sv
// USB receive-path serial CRC checker with packet framing and length checks.
// Optional feature macro: USB_CRC_ERR_CNT_EN (adds saturating err_count output).
//   clk, rst     : clock, asynchronous active-high reset
//   sop          : start of packet, valid in any state, reinitialises the checker
//   shift_enable : serial_in carries a de-stuffed bit this cycle
//   serial_in    : received bit, LSB-first
//   eop          : end of packet, closes accumulation (ignored when sop is high)
//   crc_value    : live LFSR contents
//   crc_done     : one-cycle verdict pulse
//   crc_ok       : packet passed, held until next sop
//   crc_err      : packet failed, held until next sop
//   err_count    : failed-verdict count, saturating (USB_CRC_ERR_CNT_EN only)
//   busy         : high while accumulating
module usb_crc_checker
  import usb_crc_pkg::*;
#(
  parameter int unsigned          CRC_WIDTH = 5,
  parameter logic [15:0]          POLY      = 16'h0005,
  parameter logic [CRC_WIDTH-1:0] INIT      = '1,
  parameter logic [15:0]          RESIDUE   = 16'h000C,
  parameter int unsigned          MAX_BITS  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sop,
  input  logic                 shift_enable,
  input  logic                 serial_in,
  input  logic                 eop,
  output logic [CRC_WIDTH-1:0] crc_value,
  output logic                 crc_done,
  output logic                 crc_ok,
  output logic                 crc_err,
`ifdef USB_CRC_ERR_CNT_EN
  output logic [7:0]           err_count,
`endif
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);

  crc_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 lfsr_step;
  logic [CRC_WIDTH-1:0] crc_next;

  // Bits only advance the LFSR while a packet is open (or is being opened).
  assign lfsr_step = shift_enable && (sop || (state_q == ACCUM));

  usb_crc_lfsr #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY[CRC_WIDTH-1:0]),
    .INIT      (INIT)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (sop),
    .step       (lfsr_step),
    .bit_in     (serial_in),
    .crc        (crc_value),
    .crc_next_c (crc_next)
  );

  // Framing FSM, bit counter and verdict; the verdict uses post-step values so
  // a bit arriving with eop is included.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    if (sop) begin
      state_d = ACCUM;
      cnt_d   = CNT_W'(shift_enable);
      ovf_d   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ACCUM: begin
          if (shift_enable) begin
            if (cnt_q == CNT_W'(MAX_BITS)) ovf_d = 1'b1;
            else                           cnt_d = cnt_q + CNT_W'(1);
          end
          if (eop) begin
            state_d = DONE;
            done_d  = 1'b1;
            ok_d    = (crc_next == RESIDUE[CRC_WIDTH-1:0]) &&
                      (cnt_d >= CNT_W'(CRC_WIDTH)) && !ovf_d;
            err_d   = !ok_d;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign crc_done = done_q;
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;
  assign busy     = busy_q;

`ifdef USB_CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts failed verdicts in step with the crc_done pulse, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (done_d && err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_usb_crc_checker.sv
// Scoreboard bench for usb_crc_checker: one CRC5 and one CRC16 instance.
module tb_usb_crc_checker;
  import usb_crc_pkg::*;

  typedef struct {
    logic        ok;
    logic [15:0] val;
    logic        chk_val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sop_t = 1'b0, se_t = 1'b0, si_t = 1'b0, eop_t = 1'b0;
  logic sel16 = 1'b0;

  logic sop5, se5, si5, eop5, sop16, se16, si16, eop16;
  logic [4:0]  val5;
  logic [15:0] val16;
  logic done5, ok5, err5, busy5, done16, ok16, err16, busy16;
`ifdef USB_CRC_ERR_CNT_EN
  logic [7:0] errcnt5, errcnt16;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q5[$];
  exp_t q16[$];

  assign sop5  = sop_t & ~sel16;
  assign se5   = se_t  & ~sel16;
  assign si5   = si_t  & ~sel16;
  assign eop5  = eop_t & ~sel16;
  assign sop16 = sop_t &  sel16;
  assign se16  = se_t  &  sel16;
  assign si16  = si_t  &  sel16;
  assign eop16 = eop_t &  sel16;

  always #5 clk = ~clk;

  usb_crc_checker #(
    .CRC_WIDTH (5),
    .POLY      (16'(CRC5_POLY)),
    .RESIDUE   (16'(CRC5_RESIDUE)),
    .MAX_BITS  (64)
  ) dut5 (
    .clk (clk), .rst (rst), .sop (sop5), .shift_enable (se5),
    .serial_in (si5), .eop (eop5), .crc_value (val5), .crc_done (done5),
    .crc_ok (ok5), .crc_err (err5),
`ifdef USB_CRC_ERR_CNT_EN
    .err_count (errcnt5),
`endif
    .busy (busy5)
  );

  usb_crc_checker #(
    .CRC_WIDTH (16),
    .POLY      (CRC16_POLY),
    .RESIDUE   (CRC16_RESIDUE),
    .MAX_BITS  (8200)
  ) dut16 (
    .clk (clk), .rst (rst), .sop (sop16), .shift_enable (se16),
    .serial_in (si16), .eop (eop16), .crc_value (val16), .crc_done (done16),
    .crc_ok (ok16), .crc_err (err16),
`ifdef USB_CRC_ERR_CNT_EN
    .err_count (errcnt16),
`endif
    .busy (busy16)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic e, input logic b, input logic p);
    sop_t = s; se_t = e; si_t = b; eop_t = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Packet of n bits (bits[0] first), eop on the last bit. merge puts sop on
  // the first bit; gaps inserts a cycle with shift_enable low between bits.
  task automatic send(input int n, input logic [127:0] bits, input bit merge, input bit gaps);
    if (!merge) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1 & merge & (i == 0), 1'b1, bits[i], i == n - 1);
    end
  endtask

  task automatic exp5(input logic ok, input logic [15:0] val, input logic cv);
    exp_t e;
    e.ok = ok; e.val = val; e.chk_val = cv;
    q5.push_back(e);
  endtask

  task automatic exp16(input logic ok, input logic [15:0] val, input logic cv);
    exp_t e;
    e.ok = ok; e.val = val; e.chk_val = cv;
    q16.push_back(e);
  endtask

  // Monitor: every verdict pulse must match the oldest expected verdict.
  always @(negedge clk) begin
    exp_t e;
    if (done5 === 1'b1) begin
      if (q5.size() == 0) begin
        chk("crc5 unexpected done", 16'(done5), 16'd0);
      end else begin
        e = q5.pop_front();
        chk("crc5 ok", 16'(ok5), 16'(e.ok));
        chk("crc5 err", 16'(err5), 16'(!e.ok));
        if (e.chk_val) chk("crc5 value", 16'(val5), e.val);
      end
    end
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        chk("crc16 unexpected done", 16'(done16), 16'd0);
      end else begin
        e = q16.pop_front();
        chk("crc16 ok", 16'(ok16), 16'(e.ok));
        chk("crc16 err", 16'(err16), 16'(!e.ok));
        if (e.chk_val) chk("crc16 value", val16, e.val);
      end
    end
  end

  localparam logic [127:0] T1_BITS = 128'h1000;   // 11 zeros, then 0,1,0,0,0
  localparam logic [127:0] T2_BITS = 128'h9000;   // same, last bit flipped

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset crc5 value", 16'(val5), 16'h001F);
    chk("reset crc16 value", val16, 16'hFFFF);
    chk("reset done/ok/err/busy", {12'd0, done5, ok5, err5, busy5}, 16'd0);
    rst = 1'b0;
    idle(1);

    // CRC5 good token, separate sop cycle.
    exp5(1'b1, 16'h000C, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy after sop", 16'(busy5), 16'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, T1_BITS[i], i == 15);
    idle(2);
    chk("ok held", 16'(ok5), 16'd1);
    chk("idle busy/done", {14'd0, busy5, done5}, 16'd0);

    // Same token with sop carrying the first bit.
    exp5(1'b1, 16'h000C, 1'b1);
    send(16, T1_BITS, 1'b1, 1'b0);
    idle(2);

    // Exactly CRC_WIDTH bits reaching the residue: minimum legal length.
    exp5(1'b1, 16'h000C, 1'b1);
    send(5, '0, 1'b0, 1'b0);
    idle(2);

    // CRC16 zero-length DATA0, without and with stuff gaps.
    sel16 = 1'b1;
    exp16(1'b1, 16'h800D, 1'b1);
    send(16, '0, 1'b0, 1'b0);
    idle(2);
    exp16(1'b1, 16'h800D, 1'b1);
    send(16, '0, 1'b0, 1'b1);
    idle(2);
    sel16 = 1'b0;

    // Abort: sop mid-packet, no verdict for the first packet.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    exp5(1'b1, 16'h000C, 1'b1);
    send(16, T1_BITS, 1'b0, 1'b0);
    idle(2);

    // sop with eop: sop wins, packet stays open.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("sop+eop busy", 16'(busy5), 16'd1);
    exp5(1'b1, 16'h000C, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, i == 4);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);           // bit during DONE is ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b1);           // eop in IDLE is ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("lfsr holds outside packet", 16'(val5), 16'h000C);
    chk("idle eop busy", 16'(busy5), 16'd0);

    // Corrupted token, then async reset mid-packet.
    exp5(1'b0, 16'h0009, 1'b1);
    send(16, T2_BITS, 1'b0, 1'b0);
    idle(2);
    chk("err held", 16'(err5), 16'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async rst value", 16'(val5), 16'h001F);
    chk("async rst flags", {12'd0, done5, ok5, err5, busy5}, 16'd0);
    #1 rst = 1'b0;
    idle(1);
`ifdef USB_CRC_ERR_CNT_EN
    chk("err_count after rst", 16'(errcnt5), 16'd0);
`endif

    exp5(1'b1, 16'h000C, 1'b1);
    send(16, T1_BITS, 1'b0, 1'b0);
    idle(2);

    // Three failing packets: bad CRC, too short, overlong.
    exp5(1'b0, 16'h0009, 1'b1);
    send(16, T2_BITS, 1'b0, 1'b0);
    idle(2);
    exp5(1'b0, 16'h0003, 1'b1);
    send(3, '0, 1'b0, 1'b0);
    idle(2);
    exp5(1'b0, 16'h0000, 1'b0);
    send(65, '0, 1'b0, 1'b0);
    idle(2);
`ifdef USB_CRC_ERR_CNT_EN
    chk("err_count", 16'(errcnt5), 16'd3);
`endif

    idle(5);
    chk("crc5 verdicts outstanding", 16'(q5.size()), 16'd0);
    chk("crc16 verdicts outstanding", 16'(q16.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
